// File: rtl/tpu_pkg.sv
// Shared TPU constants, FSM state type and result saturation helper.
// Used by mult_adder_128 and its lane_mac_tree datapath.
package tpu_pkg;

    localparam int OPR_W   = 8;
    localparam int VEC_LEN = 128;
    localparam int PROD_W  = 2 * OPR_W;
    localparam int RES_W   = 15;
    localparam int ACC_W   = 24;
    localparam int RES_MAX = 16383;
    localparam int RES_MIN = -16384;

    localparam logic signed [ACC_W-1:0] ACC_RES_MAX = ACC_W'(RES_MAX);
    localparam logic signed [ACC_W-1:0] ACC_RES_MIN = ACC_W'(RES_MIN);

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        SAT
    } state_e;

    typedef struct packed {
        logic             overflow;
        logic [RES_W-1:0] result;
    } sat_t;

    function automatic sat_t saturate(input logic signed [ACC_W-1:0] acc);
        sat_t s;
        if (acc > ACC_RES_MAX) begin
            s.result   = RES_W'(RES_MAX);
            s.overflow = 1'b1;
        end else if (acc < ACC_RES_MIN) begin
            s.result   = RES_W'(RES_MIN);
            s.overflow = 1'b1;
        end else begin
            s.result   = acc[RES_W-1:0];
            s.overflow = 1'b0;
        end
        return s;
    endfunction

endpackage

// File: rtl/mult_adder_128_lane_mac_tree.sv
// lane_mac_tree: LANES signed 8x8 multipliers feeding an adder tree.
// Purely combinational; produces one sign-extended beat sum.
module lane_mac_tree
    import tpu_pkg::*;
#(
    parameter int unsigned LANES = 8
) (
    input  logic [LANES*OPR_W-1:0] opr_a_i,
    input  logic [LANES*OPR_W-1:0] opr_b_i,
    output logic signed [ACC_W-1:0] sum_o
);

    logic signed [PROD_W-1:0] prod [LANES];

    always_comb begin
        for (int i = 0; i < LANES; i++) begin
            prod[i] = $signed(opr_a_i[i*OPR_W +: OPR_W]) * $signed(opr_b_i[i*OPR_W +: OPR_W]);
        end
    end

    // Synthesis balances this reduction into a tree.
    always_comb begin
        sum_o = '0;
        for (int i = 0; i < LANES; i++) begin
            sum_o = sum_o + {{(ACC_W-PROD_W){prod[i][PROD_W-1]}}, prod[i]};
        end
    end

endmodule

// File: rtl/mult_adder_128.sv
// Multi-cycle 128-element Q1.6 dot product with saturated 15-bit Q2.12 result.
// Optional build macro MULT_ADDER_RELU_EN clamps negative results to zero.
module mult_adder_128
    import tpu_pkg::*;
#(
    parameter int unsigned LANES = 8
) (
    input  logic                     clk,
    input  logic                     iRst,
    input  logic                     start,
    input  logic [VEC_LEN*OPR_W-1:0] opr1,
    input  logic [VEC_LEN*OPR_W-1:0] opr2,
    output logic                     busy,
    output logic                     done,
    output logic [RES_W-1:0]         result,
    output logic                     overflow
);

    localparam int unsigned N_BEATS = VEC_LEN / LANES;
    localparam int unsigned CNT_W   = (N_BEATS > 1) ? $clog2(N_BEATS) : 1;
    localparam int unsigned BEAT_W  = LANES * OPR_W;

    if ((VEC_LEN % LANES) != 0) begin : g_bad_lanes
        $error("LANES must divide 128");
    end

    state_e                   state_q, state_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic signed [ACC_W-1:0]  acc_q, acc_d;
    logic                     busy_q, busy_d;
    logic                     done_q, done_d;
    logic [RES_W-1:0]         result_q, result_d;
    logic                     overflow_q, overflow_d;
    logic [VEC_LEN*OPR_W-1:0] opr1_q, opr1_d;
    logic [VEC_LEN*OPR_W-1:0] opr2_q, opr2_d;
    logic signed [ACC_W-1:0]  beat_sum;
    sat_t                     sat;

    // Operands shift down one beat per cycle so the lanes always read the low bits.
    lane_mac_tree #(
        .LANES (LANES)
    ) u_lane_mac_tree (
        .opr_a_i (opr1_q[BEAT_W-1:0]),
        .opr_b_i (opr2_q[BEAT_W-1:0]),
        .sum_o   (beat_sum)
    );

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        acc_d      = acc_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        result_d   = result_q;
        overflow_d = overflow_q;
        opr1_d     = opr1_q;
        opr2_d     = opr2_q;
        sat        = saturate(acc_q);

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    opr1_d  = opr1;
                    opr2_d  = opr2;
                    acc_d   = '0;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    state_d = ACCUM;
                end
            end
            ACCUM: begin
                acc_d  = acc_q + beat_sum;
                opr1_d = opr1_q >> BEAT_W;
                opr2_d = opr2_q >> BEAT_W;
                if (cnt_q == CNT_W'(N_BEATS - 1)) begin
                    cnt_d   = '0;
                    state_d = SAT;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            SAT: begin
                result_d   = sat.result;
                overflow_d = sat.overflow;
`ifdef MULT_ADDER_RELU_EN
                if (sat.result[RES_W-1]) begin
                    result_d = '0;
                end
`endif
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge iRst) begin
        if (iRst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            acc_q      <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            result_q   <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            acc_q      <= acc_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            result_q   <= result_d;
            overflow_q <= overflow_d;
        end
    end

    // Operand registers are only meaningful after a start; no reset needed.
    always_ff @(posedge clk) begin
        opr1_q <= opr1_d;
        opr2_q <= opr2_d;
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign result   = result_q;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_mult_adder_128.sv
// Directed, table-driven bench for mult_adder_128 (LANES=8, 17-cycle latency).
// Honours MULT_ADDER_RELU_EN when the build defines it.
module tb_mult_adder_128;

    localparam int LAT = 17;

    logic          clk;
    logic          iRst;
    logic          start;
    logic [1023:0] opr1;
    logic [1023:0] opr2;
    logic          busy;
    logic          done;
    logic [14:0]   result;
    logic          overflow;

    int n_chk;
    int n_fail;

    mult_adder_128 #(
        .LANES (8)
    ) dut (
        .clk      (clk),
        .iRst     (iRst),
        .start    (start),
        .opr1     (opr1),
        .opr2     (opr2),
        .busy     (busy),
        .done     (done),
        .result   (result),
        .overflow (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string         name;
        logic [1023:0] a;
        logic [1023:0] b;
        logic [14:0]   res;
        logic          ovf;
    } vec_t;

    vec_t tv[9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [1023:0] set_el(input logic [1023:0] v, input int idx,
                                             input logic [7:0] val);
        v[8*idx +: 8] = val;
        return v;
    endfunction

    function automatic logic [1023:0] fill(input logic [7:0] val);
        logic [1023:0] v;
        for (int i = 0; i < 128; i++) v[8*i +: 8] = val;
        return v;
    endfunction

    function automatic logic [1023:0] rnd_vec();
        logic [1023:0] v;
        for (int i = 0; i < 32; i++) v[32*i +: 32] = $urandom;
        return v;
    endfunction

    // Expected result as seen at the port, given the signed saturated value.
    function automatic logic [14:0] port_res(input logic [14:0] r);
`ifdef MULT_ADDER_RELU_EN
        return r[14] ? 15'h0 : r;
`else
        return r;
`endif
    endfunction

    // Starts an operation at E0, then scrambles the operands right after.
    task automatic launch(input logic [1023:0] a, input logic [1023:0] b);
        @(negedge clk);
        opr1  = a;
        opr2  = b;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        opr1  = rnd_vec();
        opr2  = rnd_vec();
    endtask

    // Waits (bounded) for done; returns latency in cycles or -1 on timeout.
    task automatic wait_done(input int repulse_at, output int lat, output logic busy_ok);
        lat     = -1;
        busy_ok = 1'b1;
        for (int c = 1; c <= 40; c++) begin
            if (c == repulse_at) start = 1'b1;
            @(posedge clk);
            #1;
            start = 1'b0;
            if (done) begin
                lat = c;
                break;
            end
            if (!busy) busy_ok = 1'b0;
        end
    endtask

    initial begin
        int   lat;
        logic bok;
        logic seen;
        logic [1023:0] a;
        logic [1023:0] b;

        n_chk  = 0;
        n_fail = 0;
        iRst   = 1'b1;
        start  = 1'b0;
        opr1   = '0;
        opr2   = '0;

        a = set_el('0, 0, 8'h40);
        b = set_el('0, 0, 8'h20);
        tv[0] = '{"single", a, b, 15'h0800, 1'b0};
        a = set_el(set_el('0, 0, 8'hC0), 5, 8'h40);
        b = set_el(set_el('0, 0, 8'h40), 5, 8'h40);
        tv[1] = '{"cancel", a, b, 15'h0000, 1'b0};
        a = set_el('0, 0, 8'hC0);
        b = set_el('0, 0, 8'h40);
        tv[2] = '{"neg", a, b, 15'h7000, 1'b0};
        tv[3] = '{"sat_pos", fill(8'h40), fill(8'h40), 15'h3FFF, 1'b1};
        tv[4] = '{"sat_neg", fill(8'hC0), fill(8'h40), 15'h4000, 1'b1};
        a = '0;
        b = '0;
        for (int i = 0; i < 3; i++) begin
            a = set_el(a, i, 8'h40);
            b = set_el(b, i, 8'h40);
        end
        a = set_el(a, 3, 8'h3F);
        b = set_el(b, 3, 8'h41);
        tv[5] = '{"max_exact", a, b, 15'h3FFF, 1'b0};
        a = set_el(a, 3, 8'h40);
        b = set_el(b, 3, 8'h40);
        tv[6] = '{"max_plus1", a, b, 15'h3FFF, 1'b1};
        a = '0;
        b = '0;
        for (int i = 0; i < 4; i++) begin
            a = set_el(a, i, 8'hC0);
            b = set_el(b, i, 8'h40);
        end
        tv[7] = '{"min_exact", a, b, 15'h4000, 1'b0};
        a = set_el(set_el('0, 127, 8'h80), 64, 8'h02);
        b = set_el(set_el('0, 127, 8'h01), 64, 8'h03);
        tv[8] = '{"last_lane", a, b, 15'h7F86, 1'b0};

        #12;
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_done", 32'(done), 32'd0);
        chk("reset_result", 32'(result), 32'd0);
        chk("reset_overflow", 32'(overflow), 32'd0);
        @(negedge clk);
        iRst = 1'b0;

        for (int i = 0; i < 9; i++) begin
            launch(tv[i].a, tv[i].b);
            wait_done(0, lat, bok);
            chk({tv[i].name, "_latency"}, 32'(lat), 32'(LAT));
            chk({tv[i].name, "_busy"}, 32'(bok), 32'd1);
            chk({tv[i].name, "_result"}, 32'(result), 32'(port_res(tv[i].res)));
            chk({tv[i].name, "_overflow"}, 32'(overflow), 32'(tv[i].ovf));
            chk({tv[i].name, "_busy_at_done"}, 32'(busy), 32'd0);
            @(posedge clk);
            #1;
            chk({tv[i].name, "_done_pulse"}, 32'(done), 32'd0);
        end

        // start re-pulsed mid-operation is ignored
        launch(tv[0].a, tv[0].b);
        wait_done(5, lat, bok);
        chk("repulse_latency", 32'(lat), 32'(LAT));
        chk("repulse_result", 32'(result), 32'h0800);
        seen = 1'b0;
        for (int c = 0; c < 25; c++) begin
            @(posedge clk);
            #1;
            if (done) seen = 1'b1;
        end
        chk("repulse_no_second_done", 32'(seen), 32'd0);

        // back-to-back: second start issued during the done cycle
        launch(tv[2].a, tv[2].b);
        wait_done(0, lat, bok);
        chk("b2b_first_latency", 32'(lat), 32'(LAT));
        chk("b2b_first_result", 32'(result), 32'(port_res(15'h7000)));
        launch(tv[0].a, tv[0].b);
        chk("b2b_accepted_busy", 32'(busy), 32'd1);
        wait_done(0, lat, bok);
        chk("b2b_second_latency", 32'(lat), 32'(LAT));
        chk("b2b_second_result", 32'(result), 32'h0800);

        // asynchronous reset mid-operation
        launch(tv[3].a, tv[3].b);
        repeat (7) @(posedge clk);
        #3;
        iRst = 1'b1;
        #1;
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_done", 32'(done), 32'd0);
        chk("arst_result", 32'(result), 32'd0);
        chk("arst_overflow", 32'(overflow), 32'd0);
        @(negedge clk);
        iRst = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 25; c++) begin
            @(posedge clk);
            #1;
            if (done || busy) seen = 1'b1;
        end
        chk("arst_no_done", 32'(seen), 32'd0);
        launch(tv[0].a, tv[0].b);
        wait_done(0, lat, bok);
        chk("arst_recover_latency", 32'(lat), 32'(LAT));
        chk("arst_recover_result", 32'(result), 32'h0800);
        chk("arst_recover_overflow", 32'(overflow), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
